ball_frame_scanner: RTL and testbench

- Sequences one full LCD frame through the combinational ball sprite ROM.
- Walks the row address, latches each 240-bit row bitmap and serialises it into RGB565 pixels on a valid/ready stream for the LCD write engine.
- Owns the ball's vertical offset: the offset is held constant for the whole frame and advanced with bounce between limits at frame end.
- Sits between the game top-level (frame start, colours) and the sprite ROM / LCD writer.

---
 rtl/ball_frame_scanner_if.sv | 23 ++
 rtl/ball_frame_scanner.sv | 138 +++++++++++++
 tb/tb_ball_frame_scanner.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ball_frame_scanner_if.sv
// rtl/ball_frame_scanner_if.sv - sprite ROM lookup and RGB565 pixel stream bundle
interface ball_frame_scanner_if #(
    parameter int H_PIX = 240
);
    logic [8:0]       rom_addr;
    logic [8:0]       rom_offset;
    logic [H_PIX-1:0] rom_q;
    logic             pix_valid;
    logic [15:0]      pix_data;
    logic             pix_ready;

    // Scanner side: drives the ROM address/offset and sources pixels.
    modport master (
        output rom_addr, rom_offset, pix_valid, pix_data,
        input  rom_q, pix_ready
    );

    // ROM + LCD writer side.
    modport slave (
        input  rom_addr, rom_offset, pix_valid, pix_data,
        output rom_q, pix_ready
    );
endinterface

// File: rtl/ball_frame_scanner.sv
// rtl/ball_frame_scanner.sv - walks one frame through the ball ROM and streams RGB565 pixels
module ball_frame_scanner #(
    parameter int H_PIX       = 240,
    parameter int V_ROWS      = 320,
    parameter int OFFSET_MIN  = 0,
    parameter int OFFSET_MAX  = 309,
    parameter int OFFSET_INIT = 100,
    parameter int STEP        = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        move_en,
    input  logic [15:0] fg_color,
    input  logic [15:0] bg_color,
    output logic        busy,
    output logic        frame_done,
    output logic        dir_up,
    ball_frame_scanner_if.master bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FETCH     = 2'd1,
        SHIFT     = 2'd2,
        FRAME_END = 2'd3
    } state_t;

    localparam logic [7:0] COL_LAST  = 8'(H_PIX - 1);
    localparam logic [8:0] ROW_LAST  = 9'(V_ROWS - 1);
    localparam logic [9:0] STEP_W    = 10'(STEP);
    localparam logic [9:0] OFF_MAX_W = 10'(OFFSET_MAX);
    localparam logic [9:0] OFF_MIN_W = 10'(OFFSET_MIN);

    state_t           state_q, state_d;
    logic [8:0]       row_q, row_d;
    logic [7:0]       col_q, col_d;
    logic [H_PIX-1:0] buf_q, buf_d;
    logic [8:0]       addr_q, addr_d;
    logic [8:0]       off_q, off_d;
    logic             dir_q, dir_d;
    logic [9:0]       off_up;
    logic [9:0]       off_dn;

    // Offset arithmetic is one bit wider so the bounce limits compare without wrap.
    assign off_up = {1'b0, off_q} + STEP_W;
    assign off_dn = {1'b0, off_q} - STEP_W;

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
            off_q   <= 9'(OFFSET_INIT);
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            dir_q   <= dir_d;
        end
    end

    // Next-state: row fetch, pixel shift-out, and offset bounce at frame end.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        off_d   = off_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    row_d   = '0;
                    addr_d  = '0;
                end
            end
            FETCH: begin
                buf_d   = bus.rom_q;
                col_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (bus.pix_ready) begin
                    // The row buffer shifts left so its MSB is always the current column.
                    buf_d = buf_q << 1;
                    col_d = col_q + 8'd1;
                    if (col_q == COL_LAST) begin
                        if (row_q == ROW_LAST) begin
                            state_d = FRAME_END;
                        end else begin
                            row_d   = row_q + 9'd1;
                            addr_d  = row_q + 9'd1;
                            state_d = FETCH;
                        end
                    end
                end
            end
            FRAME_END: begin
                state_d = IDLE;
                if (move_en) begin
                    if (!dir_q) begin
                        if (off_up > OFF_MAX_W) begin
                            off_d = 9'(OFF_MAX_W);
                            dir_d = 1'b1;
                        end else begin
                            off_d = off_up[8:0];
                        end
                    end else begin
                        if ({1'b0, off_q} < OFF_MIN_W + STEP_W) begin
                            off_d = 9'(OFF_MIN_W);
                            dir_d = 1'b0;
                        end else begin
                            off_d = off_dn[8:0];
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rom_addr   = addr_q;
    assign bus.rom_offset = off_q;
    assign bus.pix_valid  = (state_q == SHIFT);
    assign bus.pix_data   = (state_q == SHIFT) ? (buf_q[H_PIX-1] ? fg_color : bg_color) : 16'h0000;
    assign busy           = (state_q != IDLE);
    assign frame_done     = (state_q == FRAME_END);
    assign dir_up         = dir_q;
endmodule

// File: tb/tb_ball_frame_scanner.sv
// tb/tb_ball_frame_scanner.sv - randomized self-checking bench for ball_frame_scanner
module tb_ball_frame_scanner;
    localparam int H     = 12;
    localparam int V     = 6;
    localparam int OMIN  = 0;
    localparam int OMAX  = 309;
    localparam int OINIT = 100;
    localparam int STP   = 3;
    localparam int FRAME = V * (H + 1) + 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        move_en;
    logic [15:0] fg_color;
    logic [15:0] bg_color;
    logic        busy;
    logic        frame_done;
    logic        dir_up;
    logic        bp_mode;

    ball_frame_scanner_if #(.H_PIX(H)) bus ();

    ball_frame_scanner #(
        .H_PIX(H), .V_ROWS(V), .OFFSET_MIN(OMIN), .OFFSET_MAX(OMAX),
        .OFFSET_INIT(OINIT), .STEP(STP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .move_en(move_en),
        .fg_color(fg_color), .bg_color(bg_color), .busy(busy),
        .frame_done(frame_done), .dir_up(dir_up), .bus(bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          xfers = 0;
    int          done_seen = 0;
    int          exp_done = 0;
    int          exp_off;
    bit          exp_dir;
    bit          prev_stall;
    logic [15:0] prev_data;
    logic [15:0] exp_q[$];

    // Stand-in sprite ROM: an arbitrary hash of row and offset.
    function automatic logic [H-1:0] rom_fn(input int a, input int o);
        logic [31:0] x;
        x = (a * 32'd2654435761) ^ (o * 32'd40503) ^ (a << 7);
        return x[31 -: H];
    endfunction

    assign bus.rom_q = rom_fn(int'(bus.rom_addr), int'(bus.rom_offset));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Full expected pixel sequence of one frame at the current model offset.
    task automatic fill_queue();
        logic [H-1:0] bits;
        for (int r = 0; r < V; r++) begin
            bits = rom_fn(r, exp_off);
            for (int c = 0; c < H; c++)
                exp_q.push_back(bits[H-1-c] ? fg_color : bg_color);
        end
    endtask

    // LCD writer readiness: always ready, or random stalls.
    initial begin
        bus.pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.pix_ready = bp_mode ? ($urandom_range(2) != 0) : 1'b1;
        end
    end

    // Per-cycle comparison against the frame-level model.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_off    = OINIT;
            exp_dir    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("rom_offset", 32'(bus.rom_offset), exp_off);
            chk("dir_up", 32'(dir_up), 32'(exp_dir));
            if (prev_stall) begin
                chk("stall_valid_hold", 32'(bus.pix_valid), 1);
                chk("stall_data_hold", 32'(bus.pix_data), 32'(prev_data));
            end
            if (bus.pix_valid && bus.pix_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel: got %0h expected none", bus.pix_data);
                end else begin
                    chk("pixel", 32'(bus.pix_data), 32'(exp_q.pop_front()));
                    xfers++;
                end
            end
            prev_stall = bus.pix_valid && !bus.pix_ready;
            prev_data  = bus.pix_data;
            if (frame_done) begin
                done_seen++;
                if (move_en) begin
                    if (!exp_dir) begin
                        if (exp_off + STP > OMAX) begin exp_off = OMAX; exp_dir = 1'b1; end
                        else exp_off = exp_off + STP;
                    end else begin
                        if (exp_off < OMIN + STP) begin exp_off = OMIN; exp_dir = 1'b0; end
                        else exp_off = exp_off - STP;
                    end
                end
            end
        end
    end

    task automatic run_frame(input bit bp, input bit mv, input bit spam);
        int n;
        int first_v;
        int x0;
        bit done;
        move_en  = mv;
        fg_color = 16'($urandom);
        bg_color = 16'($urandom);
        bp_mode  = bp;
        fill_queue();
        x0 = xfers;
        exp_done++;
        start   = 1'b1;
        n       = 0;
        first_v = 0;
        done    = 1'b0;
        while (!done && n < 8 * FRAME + 100) begin
            @(posedge clk);
            #1;
            n++;
            start = spam && (n == 4 || n == FRAME / 2);
            if (bus.pix_valid && first_v == 0) first_v = n;
            if (frame_done) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got no frame_done after %0d cycles expected one", n);
        end
        // A start offered during FRAME_END must be dropped.
        start = spam;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (!bp) begin
            chk("first_valid_latency", first_v, 2);
            // Cycles counted inclusively from the start cycle to the frame_done cycle.
            chk("frame_length", n + 1, FRAME);
        end
        chk("frame_transfers", xfers - x0, H * V);
        chk("queue_drained", exp_q.size(), 0);
        chk("idle_after_frame", 32'(busy), 0);
        bp_mode = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pix_valid"}, 32'(bus.pix_valid), 0);
        chk({tag, "_pix_data"}, 32'(bus.pix_data), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_frame_done"}, 32'(frame_done), 0);
        chk({tag, "_rom_addr"}, 32'(bus.rom_addr), 0);
        chk({tag, "_rom_offset"}, 32'(bus.rom_offset), 100);
        chk({tag, "_dir_up"}, 32'(dir_up), 0);
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        start    = 1'b0;
        move_en  = 1'b0;
        fg_color = 16'hF800;
        bg_color = 16'h001F;
        bp_mode  = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk_reset_outputs("idle");

        run_frame(1'b0, 1'b0, 1'b0);
        run_frame(1'b1, 1'b0, 1'b1);
        chk("offset_no_move", 32'(bus.rom_offset), 100);

        for (int k = 1; k <= 175; k++) begin
            run_frame(k % 5 == 0, 1'b1, 1'b0);
            if (k == 1)   begin chk("bounce_k1",   32'(bus.rom_offset), 103); chk("bounce_k1_dir",   32'(dir_up), 0); end
            if (k == 69)  begin chk("bounce_k69",  32'(bus.rom_offset), 307); chk("bounce_k69_dir",  32'(dir_up), 0); end
            if (k == 70)  begin chk("bounce_k70",  32'(bus.rom_offset), 309); chk("bounce_k70_dir",  32'(dir_up), 1); end
            if (k == 71)  begin chk("bounce_k71",  32'(bus.rom_offset), 306); chk("bounce_k71_dir",  32'(dir_up), 1); end
            if (k == 173) begin chk("bounce_k173", 32'(bus.rom_offset), 0);   chk("bounce_k173_dir", 32'(dir_up), 1); end
            if (k == 174) begin chk("bounce_k174", 32'(bus.rom_offset), 0);   chk("bounce_k174_dir", 32'(dir_up), 0); end
            if (k == 175) begin chk("bounce_k175", 32'(bus.rom_offset), 3);   chk("bounce_k175_dir", 32'(dir_up), 0); end
        end

        // Abort a frame mid-row with an asynchronous reset.
        move_en = 1'b0;
        fill_queue();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!(bus.rom_addr == 9'd3 && bus.pix_valid) && n < 4 * FRAME) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 4 * FRAME) begin
            checks++;
            errors++;
            $display("FAIL abort_row_wait: got rom_addr %0d expected 3 while shifting", bus.rom_addr);
        end
        repeat ($urandom_range(4)) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_abort");
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_stays_idle", 32'(busy), 0);
        run_frame(1'b0, 1'b0, 1'b0);

        repeat (10) @(posedge clk);
        #1;
        chk("frame_done_count", done_seen, exp_done);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
